controlador_estados: RTL and testbench
======================================

Name: controlador_estados

Overview:
- Pet behaviour FSM. Produces the 5-bit one-hot `estado` consumed by the attribute controller and display logic.
- Sequences INTRO → IDLE → activities (sleep, eat, teach) → MORTO from user buttons and the current fome/felicidade/sono values.
- Owns activity duration, cancel, auto-exit on a full attribute, and death detection.

Parameters:
- TICK_BITS, 26, width of the free-running prescaler; one tick per 2^TICK_BITS clocks.
- ACT_TICKS, 8'd20, maximum ticks an activity lasts before returning to IDLE.
- DEATH_TICKS, 8'd5, consecutive ticks with any attribute at 0 before death.
- LOW_THRESH, 8'd20, alert threshold for attributes.
- MAX_ATTR, 8'd100, full-attribute value.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_start  in  1  start/restart button, synchronous level.
- btn_dormir  in  1  sleep request/cancel, level.
- btn_comer  in  1  eat request/cancel, level.
- btn_aula  in  1  teach request/cancel, level.
- fome  in  8  current hunger attribute.
- felicidade  in  8  current happiness attribute.
- sono  in  8  current sleep attribute.
- estado  out  5  one-hot state: INTRO=00000, IDLE=00001, DORMINDO=00010, COMENDO=00100, DANDO_AULA=01000, MORTO=10000.
- alerta  out  1  registered; high when any attribute < LOW_THRESH and estado ∉ {INTRO, MORTO}.
- tick  out  1  prescaler pulse, one clk wide.

Behaviour:
- Reset (async, rst=1):
  - estado=INTRO, alerta=0.
  - Prescaler=0, act_cnt=0, zero_cnt=0, button history regs=0.
- Prescaler:
  - Increments every clk and wraps modulo 2^TICK_BITS.
  - tick=1 combinationally whenever the prescaler==0, including the first cycle after reset release.
- Buttons:
  - Rising edge = level high while the registered previous value is low.
  - Edge sampled at cycle N → estado updates at edge N+1 (1-cycle latency).
  - A held button produces exactly one edge.
- INTRO: btn_start edge → IDLE. All other inputs are ignored, and no death counting occurs.
- IDLE:
  - Edge priority on simultaneous presses: dormir > comer > aula.
  - dormir edge → DORMINDO; comer edge → COMENDO; aula edge → DANDO_AULA.
  - act_cnt cleared on entry to any activity.
- Activity states (DORMINDO / COMENDO / DANDO_AULA): return to IDLE at the first of:
  - edge of the same button (cancel);
  - target attribute (sono / fome / felicidade respectively) >= MAX_ATTR;
  - tick while act_cnt == ACT_TICKS-1.
  - Otherwise act_cnt increments on each tick.
  - Edges of other buttons, and btn_start, are ignored.
- Death detection, in IDLE and all activity states:
  - On each tick, if any attribute == 0 then zero_cnt += 1, else zero_cnt = 0.
  - When a tick would bring zero_cnt to DEATH_TICKS → MORTO.
  - Death has priority over every other transition in the same cycle.
  - zero_cnt saturates; it never wraps.
- MORTO: btn_start edge → INTRO, clearing act_cnt and zero_cnt. Other buttons are ignored.
- Counters are 8-bit. ACT_TICKS and DEATH_TICKS must be ≥ 1; with value 1 the transition happens on the first tick.
- Illegal estado encodings (e.g. after an SEU) → IDLE at the next clk.
- rst asserted mid-activity → INTRO immediately. The prescaler restarts at 0.

Optional Feature:
- Macro: AUTO_SLEEP_EN.
- Defined:
  - In IDLE with no button edge, sono < LOW_THRESH at a tick → DORMINDO, with act_cnt cleared.
  - A button edge in the same cycle takes precedence.
  - Death still has priority.
- Undefined: IDLE leaves only on button edges or death.

Test Plan (TICK_BITS=4, ACT_TICKS=3, DEATH_TICKS=2):
1. Reset, then btn_start pulse → estado 00000→00001 one clk after the edge. alerta=0 with attributes 80/70/50.
2. IDLE, btn_dormir and btn_comer rise in the same cycle → estado=00010. Holding both for 10 clks causes no further change; btn_dormir re-pulse → 00001.
3. COMENDO, fome=50 held constant → returns to 00001 on the 3rd tick (clk 48 after entry, ±1). With fome=100, returns after 1 clk.
4. IDLE, sono=0 → after 2 ticks estado=10000. A btn_aula edge in the same cycle as the death tick is ignored. btn_aula in MORTO: no change. btn_start → 00000.
5. DANDO_AULA with felicidade=0 for one tick, then 30 → zero_cnt clears, no death. alerta=1 when felicidade=10, 0 at 30.
6. rst pulse mid-DORMINDO → estado=00000 asynchronously, before the next clk edge. With AUTO_SLEEP_EN defined, IDLE with sono=10 → 00010 at the next tick.

Source files
------------

// File: rtl/controlador_estados.sv
// Pet behaviour FSM: INTRO -> IDLE -> activities (sleep/eat/teach) -> MORTO, with a
// free-running tick prescaler. Define AUTO_SLEEP_EN to let IDLE fall asleep on low sono.
module controlador_estados #(
    parameter int unsigned TICK_BITS   = 26,
    parameter logic [7:0]  ACT_TICKS   = 8'd20,
    parameter logic [7:0]  DEATH_TICKS = 8'd5,
    parameter logic [7:0]  LOW_THRESH  = 8'd20,
    parameter logic [7:0]  MAX_ATTR    = 8'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_dormir,
    input  logic       btn_comer,
    input  logic       btn_aula,
    input  logic [7:0] fome,
    input  logic [7:0] felicidade,
    input  logic [7:0] sono,
    output logic [4:0] estado,
    output logic       alerta,
    output logic       tick
);

    typedef enum logic [4:0] {
        INTRO      = 5'b00000,
        IDLE       = 5'b00001,
        DORMINDO   = 5'b00010,
        COMENDO    = 5'b00100,
        DANDO_AULA = 5'b01000,
        MORTO      = 5'b10000
    } estado_t;

    localparam logic [TICK_BITS-1:0] PRESC_ONE = {{(TICK_BITS-1){1'b0}}, 1'b1};

    logic [TICK_BITS-1:0] presc_q;
    logic [3:0]           btn_q;
    estado_t              estado_q, estado_d;
    logic [7:0]           act_cnt_q, act_cnt_d;
    logic [7:0]           zero_cnt_q, zero_cnt_d;
    logic                 alerta_q;

    logic [3:0] btn_now;
    logic [3:0] btn_edge;
    logic       any_zero;
    logic       any_low;
    logic [7:0] zero_inc;
    logic       death;
    logic       act_done;
    logic       counting;

    // Button bit order: 0 start, 1 dormir, 2 comer, 3 aula.
    assign btn_now  = {btn_aula, btn_comer, btn_dormir, btn_start};
    assign btn_edge = btn_now & ~btn_q;

    assign tick     = (presc_q == '0);
    assign any_zero = (fome == 8'd0) || (felicidade == 8'd0) || (sono == 8'd0);
    assign any_low  = (fome < LOW_THRESH) || (felicidade < LOW_THRESH) || (sono < LOW_THRESH);
    assign zero_inc = (zero_cnt_q == 8'hFF) ? zero_cnt_q : zero_cnt_q + 8'd1;
    assign counting = (estado_q == IDLE) || (estado_q == DORMINDO) ||
                      (estado_q == COMENDO) || (estado_q == DANDO_AULA);
    assign death    = counting && tick && any_zero && (zero_inc >= DEATH_TICKS);
    assign act_done = tick && (act_cnt_q >= ACT_TICKS - 8'd1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        estado_d   = estado_q;
        act_cnt_d  = act_cnt_q;
        zero_cnt_d = zero_cnt_q;

        if (counting && tick) begin
            zero_cnt_d = any_zero ? zero_inc : 8'd0;
        end

        case (estado_q)
            INTRO: begin
                if (btn_edge[0]) estado_d = IDLE;
            end
            IDLE: begin
                if (death) begin
                    estado_d = MORTO;
                end else if (btn_edge[1]) begin
                    estado_d  = DORMINDO;
                    act_cnt_d = 8'd0;
                end else if (btn_edge[2]) begin
                    estado_d  = COMENDO;
                    act_cnt_d = 8'd0;
                end else if (btn_edge[3]) begin
                    estado_d  = DANDO_AULA;
                    act_cnt_d = 8'd0;
`ifdef AUTO_SLEEP_EN
                end else if (tick && (sono < LOW_THRESH)) begin
                    estado_d  = DORMINDO;
                    act_cnt_d = 8'd0;
`endif
                end
            end
            DORMINDO: begin
                if (death) estado_d = MORTO;
                else if (btn_edge[1] || (sono >= MAX_ATTR) || act_done) estado_d = IDLE;
                else if (tick) act_cnt_d = act_cnt_q + 8'd1;
            end
            COMENDO: begin
                if (death) estado_d = MORTO;
                else if (btn_edge[2] || (fome >= MAX_ATTR) || act_done) estado_d = IDLE;
                else if (tick) act_cnt_d = act_cnt_q + 8'd1;
            end
            DANDO_AULA: begin
                if (death) estado_d = MORTO;
                else if (btn_edge[3] || (felicidade >= MAX_ATTR) || act_done) estado_d = IDLE;
                else if (tick) act_cnt_d = act_cnt_q + 8'd1;
            end
            MORTO: begin
                if (btn_edge[0]) begin
                    estado_d   = INTRO;
                    act_cnt_d  = 8'd0;
                    zero_cnt_d = 8'd0;
                end
            end
            // Corrupted encodings recover through IDLE.
            default: estado_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            btn_q      <= 4'b0000;
            estado_q   <= INTRO;
            act_cnt_q  <= 8'd0;
            zero_cnt_q <= 8'd0;
            alerta_q   <= 1'b0;
        end else begin
            presc_q    <= presc_q + PRESC_ONE;
            btn_q      <= btn_now;
            estado_q   <= estado_d;
            act_cnt_q  <= act_cnt_d;
            zero_cnt_q <= zero_cnt_d;
            alerta_q   <= any_low && (estado_d != INTRO) && (estado_d != MORTO);
        end
    end

    assign estado = estado_q;
    assign alerta = alerta_q;

endmodule

// File: tb/tb_controlador_estados.sv
// Directed bench for controlador_estados with TICK_BITS=4, ACT_TICKS=3, DEATH_TICKS=2.
// Ticks land on clock edges n = 1, 17, 33, ... counted from reset release.
module tb_controlador_estados;

    localparam logic [4:0] ST_INTRO = 5'b00000;
    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_DORM  = 5'b00010;
    localparam logic [4:0] ST_COME  = 5'b00100;
    localparam logic [4:0] ST_AULA  = 5'b01000;
    localparam logic [4:0] ST_MORTO = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start, btn_dormir, btn_comer, btn_aula;
    logic [7:0] fome, felicidade, sono;
    logic [4:0] estado;
    logic       alerta;
    logic       tick;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;

    controlador_estados #(
        .TICK_BITS  (4),
        .ACT_TICKS  (8'd3),
        .DEATH_TICKS(8'd2),
        .LOW_THRESH (8'd20),
        .MAX_ATTR   (8'd100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_dormir(btn_dormir),
        .btn_comer (btn_comer),
        .btn_aula  (btn_aula),
        .fome      (fome),
        .felicidade(felicidade),
        .sono      (sono),
        .estado    (estado),
        .alerta    (alerta),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check_st(input string tag, input logic [4:0] exp);
        vectors++;
        assert (estado === exp) else begin
            miscompares++;
            $error("FAIL %s: estado observed %b expected %b (n=%0d)", tag, estado, exp, n);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        #1;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        n   = 0;
    endtask

    initial begin
        rst = 1'b1;
        btn_start = 1'b0; btn_dormir = 1'b0; btn_comer = 1'b0; btn_aula = 1'b0;
        fome = 8'd80; felicidade = 8'd70; sono = 8'd50;
        repeat (2) @(posedge clk);
        #1;
        check_st("reset_estado", ST_INTRO);
        check_bit("reset_alerta", alerta, 1'b0);
        check_bit("reset_tick", tick, 1'b1);

        // Start button leaves INTRO on the first edge after release.
        release_reset();
        check_bit("tick_first_cycle", tick, 1'b1);
        btn_start = 1'b1;
        step();
        check_st("start_to_idle", ST_IDLE);
        check_bit("alerta_attrs_ok", alerta, 1'b0);
        check_bit("tick_n1_low", tick, 1'b0);

        // Simultaneous dormir+comer: dormir wins; holding produces no further edges.
        btn_start = 1'b0; btn_dormir = 1'b1; btn_comer = 1'b1;
        step();
        check_st("priority_dormir", ST_DORM);
        run_to(12);
        check_st("held_no_change", ST_DORM);
        btn_dormir = 1'b0; btn_comer = 1'b0;
        step();
        btn_dormir = 1'b1;
        step();
        check_st("dormir_cancel", ST_IDLE);
        btn_dormir = 1'b0;
        step();

        // COMENDO entered at n=16, ticks at 17/33/49, timeout on the third.
        btn_comer = 1'b1;
        step();
        check_st("enter_comendo", ST_COME);
        check_bit("tick_n16", tick, 1'b1);
        btn_comer = 1'b0;
        run_to(48);
        check_st("comendo_before_timeout", ST_COME);
        step();
        check_st("comendo_timeout", ST_IDLE);
        btn_comer = 1'b1;
        step();
        check_st("reenter_comendo", ST_COME);
        fome = 8'd100;
        step();
        check_st("comendo_full_exit", ST_IDLE);

        // sono=0 in IDLE: zero ticks at 65 and 81, death at 81 beats aula edge.
        btn_comer = 1'b0; fome = 8'd50; sono = 8'd0;
        step();
        check_bit("alerta_sono_zero", alerta, 1'b1);
        run_to(80);
        check_st("idle_before_death", ST_IDLE);
        btn_aula = 1'b1;
        step();
        check_st("death_over_aula", ST_MORTO);
        check_bit("alerta_morto", alerta, 1'b0);
        btn_aula = 1'b0;
        step();
        btn_aula = 1'b1;
        step();
        check_st("morto_ignores_aula", ST_MORTO);
        btn_aula = 1'b0; btn_start = 1'b1;
        step();
        check_st("morto_restart", ST_INTRO);
        btn_start = 1'b0; sono = 8'd50;
        step();
        btn_start = 1'b1;
        step();
        check_st("restart_idle", ST_IDLE);

        // DANDO_AULA from n=87, ticks 97/113/129; one zero tick then recovery.
        btn_start = 1'b0; btn_aula = 1'b1;
        step();
        check_st("enter_aula", ST_AULA);
        btn_aula = 1'b0; felicidade = 8'd0;
        step();
        check_bit("alerta_fel_zero", alerta, 1'b1);
        run_to(97);
        check_st("aula_after_zero_tick", ST_AULA);
        felicidade = 8'd10;
        step();
        check_bit("alerta_fel10", alerta, 1'b1);
        run_to(105);
        felicidade = 8'd30;
        step();
        check_bit("alerta_fel30", alerta, 1'b0);
        run_to(113);
        felicidade = 8'd0;
        run_to(128);
        check_st("aula_no_death_yet", ST_AULA);
        step();
        check_st("aula_timeout_not_death", ST_IDLE);
        felicidade = 8'd30;
        step();

        // Asynchronous reset in the middle of DORMINDO.
        btn_dormir = 1'b1;
        step();
        check_st("enter_dormindo", ST_DORM);
        btn_dormir = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_st("async_reset", ST_INTRO);
        check_bit("async_reset_tick", tick, 1'b1);
        check_bit("async_reset_alerta", alerta, 1'b0);

        // Low sono in IDLE across a tick: auto-sleep only when the feature is built in.
        release_reset();
        btn_start = 1'b1;
        step();
        check_st("idle_again", ST_IDLE);
        btn_start = 1'b0; sono = 8'd10;
        run_to(16);
        check_st("idle_before_tick", ST_IDLE);
        step();
`ifdef AUTO_SLEEP_EN
        check_st("auto_sleep", ST_DORM);
`else
        check_st("no_auto_sleep", ST_IDLE);
`endif
        check_bit("alerta_sono_low", alerta, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
